// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared FSM state, bus cycle type and wait-counter width for the Z80 bus slave.
package z80_bus_pkg;
    localparam int WCNT_W = 4;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAITCNT, S_DONE} state_t;
    typedef enum logic [1:0] {CYC_MEM, CYC_IO, CYC_INTA} cyc_t;
endpackage

// File: rtl/z80_wait_timer.sv
// z80_wait_timer: loadable down-counter; zero_o reflects the count after this cycle's update.
module z80_wait_timer
    import z80_bus_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [WCNT_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              zero_o
);
    logic [WCNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d  = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - WCNT_W'(1) : cnt_q;
        zero_o = cnt_d == '0;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/z80_bus_slave.sv
// z80_bus_slave: turns Z80 memory/I-O/INTA bus cycles into a req/ack back-end handshake,
// holding the CPU with nWAIT until the back end answers plus WAIT_MIN extra cycles.
module z80_bus_slave
    import z80_bus_pkg::*;
#(
    parameter int unsigned WAIT_MIN   = 0,
    parameter logic [7:0]  INT_VECTOR = 8'hFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        nM1,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nRFSH,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    output logic        nWAIT,
    output logic        mem_req,
    output logic        mem_io,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);
    state_t      state_q, state_d;
    cyc_t        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  data_q, data_d;
    logic        nwait_q, nwait_d;
    logic        err_q, err_d;
    logic        abort_q, abort_d;
    logic        ign_q, ign_d;
    logic        load, zero;
    logic        mem_det, io_det, inta_det, active, all_high;

    z80_wait_timer u_timer (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .load_i     (load),
        .load_val_i (WCNT_W'(WAIT_MIN)),
        .dec_i      (state_q == S_WAITCNT),
        .zero_o     (zero)
    );

    always_comb begin
        mem_det  = !nMREQ && nRFSH && (!nRD || !nWR);
        io_det   = !nIORQ && nM1 && (!nRD || !nWR);
        inta_det = !nIORQ && !nM1;
        active   = (we_q ? !nWR : !nRD) && (cyc_q == CYC_IO ? !nIORQ : !nMREQ);
        all_high = nMREQ && nIORQ && nRD && nWR;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cyc_q   <= CYC_MEM;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            nwait_q <= 1'b1;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            ign_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            nwait_q <= nwait_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            ign_q   <= ign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        abort_d = abort_q;
        err_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // acks left over from before a reset are not treated as violations
                err_d = (!nMREQ && !nIORQ) || (mem_ack && !ign_q);
                if (mem_det || io_det) begin
                    state_d = S_REQ;
                    cyc_d   = mem_det ? CYC_MEM : CYC_IO;
                    we_d    = !nWR;
                    addr_d  = A;
                    wdata_d = D_in;
                    abort_d = 1'b0;
                end else if (inta_det) begin
                    state_d = S_DONE;
                    cyc_d   = CYC_INTA;
                    we_d    = 1'b0;
                    data_d  = INT_VECTOR;
                end
            end
            S_REQ: begin
                if (!active && !abort_q) begin
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                end
                if (mem_ack) begin
                    load    = 1'b1;
                    data_d  = we_q ? data_q : mem_rdata;
                    state_d = (!active || abort_q) ? S_IDLE : (WAIT_MIN > 0) ? S_WAITCNT : S_DONE;
                end
            end
            S_WAITCNT: begin
                err_d   = mem_ack || !active;
                state_d = !active ? S_IDLE : zero ? S_DONE : S_WAITCNT;
            end
            S_DONE: begin
                err_d   = mem_ack;
                state_d = all_high ? S_IDLE : S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        nwait_d = !(state_d == S_REQ || state_d == S_WAITCNT);
        ign_d   = ign_q && state_d == S_IDLE;
    end

    always_comb begin
        mem_req   = state_q == S_REQ;
        mem_io    = cyc_q == CYC_IO;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        D_out     = data_q;
        D_oe      = state_q == S_DONE && !we_q;
        nWAIT     = nwait_q;
        bus_err   = err_q;
    end
endmodule

// File: tb/tb_z80_bus_slave.sv
// tb_z80_bus_slave: directed checks of two slaves (WAIT_MIN=0/INT_VECTOR=CF and WAIT_MIN=3) on a shared bus.
module tb_z80_bus_slave;
    logic        CLK = 1'b0;
    logic        RESET, nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, mem_ack;
    logic [15:0] A;
    logic [7:0]  D_in, mem_rdata;
    logic [7:0]  dout0, dout3, wdata0, wdata3;
    logic [15:0] addr0, addr3;
    logic        oe0, oe3, nwait0, nwait3, req0, req3, io0, io3, we0, we3, err0, err3;
    logic [37:0] st0, st3;
    int          total = 0, passed = 0, fails = 0;
    int          req0_n = 0, err0_n = 0, oe0_n = 0, err3_n = 0, oe3_n = 0;
    logic        req0_p = 1'b0;
    int          r0s, e0s, o0s, e3s, o3s;
    localparam logic [37:0] RST_V = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0};

    always #5 CLK = ~CLK;

    z80_bus_slave #(.WAIT_MIN(0), .INT_VECTOR(8'hCF)) u0 (
        .CLK(CLK), .RESET(RESET), .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
        .nRFSH(nRFSH), .A(A), .D_in(D_in), .D_out(dout0), .D_oe(oe0), .nWAIT(nwait0),
        .mem_req(req0), .mem_io(io0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(err0));

    z80_bus_slave #(.WAIT_MIN(3)) u3 (
        .CLK(CLK), .RESET(RESET), .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
        .nRFSH(nRFSH), .A(A), .D_in(D_in), .D_out(dout3), .D_oe(oe3), .nWAIT(nwait3),
        .mem_req(req3), .mem_io(io3), .mem_we(we3), .mem_addr(addr3), .mem_wdata(wdata3),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(err3));

    assign st0 = {nwait0, oe0, dout0, req0, io0, we0, addr0, wdata0, err0};
    assign st3 = {nwait3, oe3, dout3, req3, io3, we3, addr3, wdata3, err3};

    always @(negedge CLK) begin
        if (req0 && !req0_p) req0_n++;
        req0_p = req0;
        if (err0) err0_n++;
        if (oe0) oe0_n++;
        if (err3) err3_n++;
        if (oe3) oe3_n++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        r0s = req0_n; e0s = err0_n; o0s = oe0_n; e3s = err3_n; o3s = oe3_n;
    endtask

    initial begin
        RESET = 1'b1; nM1 = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
        A = '0; D_in = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick(); tick();
        chk("reset_u0", 64'(st0), 64'(RST_V));
        chk("reset_u3", 64'(st3), 64'(RST_V));
        RESET = 1'b0;
        tick();
        // memory read, ack two cycles after mem_req rises
        snap();
        nMREQ = 1'b0; nRD = 1'b0; A = 16'h1234;
        tick();
        chk("rd_req", 64'({req0, io0, we0, addr0, nwait0}), 64'({1'b1, 1'b0, 1'b0, 16'h1234, 1'b0}));
        tick();
        chk("rd_hold", 64'({req0, nwait0}), 64'({1'b1, 1'b0}));
        tick();
        chk("rd_wait3", 64'({req0, nwait0}), 64'({1'b1, 1'b0}));
        mem_ack = 1'b1; mem_rdata = 8'hA5;
        tick();
        mem_ack = 1'b0;
        chk("rd_done", 64'({req0, nwait0, oe0, dout0}), 64'({1'b0, 1'b1, 1'b1, 8'hA5}));
        tick();
        chk("rd_drive", 64'({oe0, dout0}), 64'({1'b1, 8'hA5}));
        tick();
        chk("rd_u3_wait", 64'(nwait3), 64'(1'b0));
        tick();
        chk("rd_u3_done", 64'({nwait3, oe3, dout3}), 64'({1'b1, 1'b1, 8'hA5}));
        nMREQ = 1'b1; nRD = 1'b1;
        tick();
        chk("rd_release", 64'({oe0, oe3, nwait0}), 64'({1'b0, 1'b0, 1'b1}));
        chk("rd_no_err", 64'(err0_n - e0s), 64'd0);
        tick();
        // I/O write with immediate ack
        snap();
        nIORQ = 1'b0; nWR = 1'b0; A = 16'h00FE; D_in = 8'h3C;
        tick();
        chk("io_req", 64'({req3, io3, we3, addr3, wdata3}), 64'({1'b1, 1'b1, 1'b1, 16'h00FE, 8'h3C}));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("io_acked", 64'({req3, nwait3}), 64'({1'b0, 1'b0}));
        tick(); tick();
        chk("io_wait_last", 64'(nwait3), 64'(1'b0));
        tick();
        chk("io_nwait_rel", 64'(nwait3), 64'(1'b1));
        nIORQ = 1'b1; nWR = 1'b1;
        tick();
        chk("io_no_oe", 64'(oe3_n - o3s), 64'd0);
        chk("io_no_err", 64'(err3_n - e3s), 64'd0);
        tick();
        // interrupt acknowledge
        snap();
        nM1 = 1'b0; nIORQ = 1'b0;
        tick();
        chk("inta_u0", 64'({req0, nwait0, oe0, dout0}), 64'({1'b0, 1'b1, 1'b1, 8'hCF}));
        chk("inta_u3_vec", 64'(dout3), 64'(8'hFF));
        nM1 = 1'b1; nIORQ = 1'b1;
        tick();
        chk("inta_release", 64'(oe0), 64'(1'b0));
        chk("inta_no_req", 64'(req0_n - r0s), 64'd0);
        tick();
        // refresh, then back-to-back memory write
        snap();
        nMREQ = 1'b0; nRFSH = 1'b0; A = 16'h0055;
        tick();
        chk("rfsh_ignored", 64'(req0), 64'(1'b0));
        nRFSH = 1'b1; nWR = 1'b0; A = 16'h4000; D_in = 8'h77;
        tick();
        chk("wr_req", 64'({req0, we0, addr0, wdata0}), 64'({1'b1, 1'b1, 16'h4000, 8'h77}));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("wr_done", 64'({nwait0, oe0}), 64'({1'b1, 1'b0}));
        nMREQ = 1'b1; nWR = 1'b1;
        tick();
        chk("wr_one_req", 64'(req0_n - r0s), 64'd1);
        chk("wr_no_err", 64'(err0_n - e0s), 64'd0);
        tick();
        // reset during WAITCNT, stray ack afterwards
        nMREQ = 1'b0; nRD = 1'b0; A = 16'hABCD;
        tick();
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        tick();
        mem_ack = 1'b0;
        chk("rst_in_wait", 64'(nwait3), 64'(1'b0));
        RESET = 1'b1;
        tick();
        chk("rst_u3_vals", 64'(st3), 64'(RST_V));
        RESET = 1'b0; nMREQ = 1'b1; nRD = 1'b1; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("stray_u3", 64'(st3), 64'(RST_V));
        chk("stray_u0_err", 64'(err0), 64'(1'b0));
        nMREQ = 1'b0; nRD = 1'b0; A = 16'h0101;
        tick();
        chk("post_rst_req", 64'({req3, addr3}), 64'({1'b1, 16'h0101}));
        mem_ack = 1'b1; mem_rdata = 8'hC3;
        tick();
        mem_ack = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_rd", 64'({nwait3, oe3, dout3}), 64'({1'b1, 1'b1, 8'hC3}));
        nMREQ = 1'b1; nRD = 1'b1;
        tick(); tick();
        // nRD released while the request is outstanding
        snap();
        nMREQ = 1'b0; nRD = 1'b0; A = 16'h2222;
        tick();
        chk("ab_req", 64'(req0), 64'(1'b1));
        nMREQ = 1'b1; nRD = 1'b1;
        tick();
        chk("ab_err", 64'({req0, err0}), 64'({1'b1, 1'b1}));
        tick();
        chk("ab_err_once", 64'({req0, err0}), 64'({1'b1, 1'b0}));
        tick();
        mem_ack = 1'b1; mem_rdata = 8'h99;
        tick();
        mem_ack = 1'b0;
        chk("ab_idle", 64'({req0, oe0, nwait0}), 64'({1'b0, 1'b0, 1'b1}));
        tick();
        chk("ab_err_cnt", 64'(err0_n - e0s), 64'd1);
        chk("ab_no_oe", 64'(oe0_n - o0s), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
